// File: rtl/dac_sched_pkg.sv
// Shared definitions for the DAC sample scheduler: FSM encoding and default sample width.
package dac_sched_pkg;

    localparam int DAC_DATA_NBIT = 20;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        PUSH  = 3'd3,
        HOLD  = 3'd4
    } state_t;

endpackage

// File: rtl/dac_tick_gen.sv
// Sample-period divider: emits one tick every period+1 mclk cycles.
module dac_tick_gen #(
    parameter int DIV_NBIT = 16
) (
    input  logic                mclk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic [DIV_NBIT-1:0] period,
    output logic                tick
);

    logic [DIV_NBIT-1:0] count;

    assign tick = (count == period);

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/dac_sched.sv
// Waveform playback scheduler: fetches samples from memory, pushes them to the
// DAC serializer FIFO and fires dac_start once per sample period.
module dac_sched
    import dac_sched_pkg::*;
#(
    parameter int DATA_NBIT = DAC_DATA_NBIT,
    parameter int ADDR_NBIT = 10,
    parameter int DIV_NBIT  = 16
) (
    input  logic                 mclk,
    input  logic                 rst_n,
    input  logic                 cfg_en,
    input  logic [ADDR_NBIT-1:0] cfg_start_addr,
    input  logic [ADDR_NBIT-1:0] cfg_end_addr,
    input  logic                 cfg_loop,
    input  logic [DIV_NBIT-1:0]  cfg_period,
    output logic                 mem_rd,
    output logic [ADDR_NBIT-1:0] mem_addr,
    input  logic [DATA_NBIT-1:0] mem_rdata,
    output logic                 tx_dv,
    output logic [DATA_NBIT-1:0] tx_data,
    input  logic                 tx_waitrequest,
    output logic                 dac_start,
    output logic                 busy,
    output logic                 done,
    output logic                 underrun
);

    state_t               state;
    state_t               state_nxt;
    logic                 en_prev;
    logic [ADDR_NBIT-1:0] addr;
    logic [ADDR_NBIT-1:0] start_q;
    logic [ADDR_NBIT-1:0] end_q;
    logic                 loop_q;
    logic [DIV_NBIT-1:0]  period_q;
    logic [DATA_NBIT-1:0] data_q;

    logic en_rise;
    logic at_end;
    logic tick;
    logic latch_cfg;
    logic load_data;
    logic addr_step;
    logic addr_reload;

    assign en_rise  = cfg_en & ~en_prev;
    assign at_end   = (addr == end_q);
    assign busy     = (state != IDLE);
    assign mem_addr = addr;
    assign tx_data  = data_q;

    // Counter is held cleared while idle, so it restarts at 0 on the cycle playback begins.
    dac_tick_gen #(
        .DIV_NBIT(DIV_NBIT)
    ) u_tick_gen (
        .mclk  (mclk),
        .rst_n (rst_n),
        .clr   (state == IDLE),
        .period(period_q),
        .tick  (tick)
    );

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Dropping cfg_en aborts everywhere except PUSH, where the pending transfer
    // must finish first so tx_dv never falls while the FIFO is stalling.
    always_comb begin
        state_nxt   = state;
        mem_rd      = 1'b0;
        tx_dv       = 1'b0;
        dac_start   = 1'b0;
        done        = 1'b0;
        underrun    = 1'b0;
        latch_cfg   = 1'b0;
        load_data   = 1'b0;
        addr_step   = 1'b0;
        addr_reload = 1'b0;
        unique case (state)
            IDLE: begin
                if (en_rise) begin
                    latch_cfg = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                mem_rd    = 1'b1;
                underrun  = tick;
                state_nxt = cfg_en ? LOAD : IDLE;
            end
            LOAD: begin
                underrun = tick;
                if (cfg_en) begin
                    load_data = 1'b1;
                    state_nxt = PUSH;
                end else begin
                    state_nxt = IDLE;
                end
            end
            PUSH: begin
                tx_dv    = 1'b1;
                underrun = tick;
                if (!tx_waitrequest) begin
                    state_nxt = cfg_en ? HOLD : IDLE;
                end
            end
            HOLD: begin
                if (!cfg_en) begin
                    state_nxt = IDLE;
                end else if (tick) begin
                    dac_start = 1'b1;
                    if (!at_end) begin
                        addr_step = 1'b1;
                        state_nxt = FETCH;
                    end else if (loop_q) begin
                        addr_reload = 1'b1;
                        state_nxt   = FETCH;
                    end else begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            en_prev  <= 1'b0;
            start_q  <= '0;
            end_q    <= '0;
            loop_q   <= 1'b0;
            period_q <= '0;
            addr     <= '0;
        end else begin
            en_prev <= cfg_en;
            if (latch_cfg) begin
                start_q  <= cfg_start_addr;
                end_q    <= cfg_end_addr;
                loop_q   <= cfg_loop;
                period_q <= cfg_period;
                addr     <= cfg_start_addr;
            end else if (addr_reload) begin
                addr <= start_q;
            end else if (addr_step) begin
                // Natural wrap lets start > end play through the top of memory.
                addr <= addr + 1'b1;
            end
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load_data) begin
            data_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dac_sched.sv
// Testbench for dac_sched: table-driven one-shot runs plus hand-written
// loop, back-pressure, abort and reset sequences, checked by a scoreboard.
module tb_dac_sched;

    localparam int DN = 20;
    localparam int AN = 10;
    localparam int PN = 16;

    logic          mclk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_en = 1'b0;
    logic [AN-1:0] cfg_start_addr = '0;
    logic [AN-1:0] cfg_end_addr = '0;
    logic          cfg_loop = 1'b0;
    logic [PN-1:0] cfg_period = '0;
    logic          mem_rd;
    logic [AN-1:0] mem_addr;
    logic [DN-1:0] mem_rdata = '0;
    logic          tx_dv;
    logic [DN-1:0] tx_data;
    logic          tx_waitrequest = 1'b0;
    logic          dac_start;
    logic          busy;
    logic          done;
    logic          underrun;

    // Scoreboard queues: expected read addresses and expected FIFO samples.
    logic [AN-1:0] exp_addr_q[$];
    logic [DN-1:0] exp_q[$];

    int n_checks = 0;
    int n_fail = 0;
    int n_start = 0;
    int n_done = 0;
    int n_under = 0;
    int n_xfer = 0;
    int cyc = 0;
    int last_start = 0;
    bit have_last = 1'b0;
    bit chk_int = 1'b0;
    bit sb_on = 1'b1;
    bit stall_prev = 1'b0;
    logic [DN-1:0] stall_data = '0;

    typedef struct {
        logic [AN-1:0] start_a;
        logic [AN-1:0] end_a;
        logic [PN-1:0] period;
        int            exp_under;
    } case_t;

    case_t cases[4];

    always #5 mclk = ~mclk;

    dac_sched dut (
        .mclk          (mclk),
        .rst_n         (rst_n),
        .cfg_en        (cfg_en),
        .cfg_start_addr(cfg_start_addr),
        .cfg_end_addr  (cfg_end_addr),
        .cfg_loop      (cfg_loop),
        .cfg_period    (cfg_period),
        .mem_rd        (mem_rd),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .tx_dv         (tx_dv),
        .tx_data       (tx_data),
        .tx_waitrequest(tx_waitrequest),
        .dac_start     (dac_start),
        .busy          (busy),
        .done          (done),
        .underrun      (underrun)
    );

    // Waveform memory model: mem[i] = i + 0x100, one-cycle read latency.
    always @(posedge mclk) begin
        cyc <= cyc + 1;
        if (mem_rd) mem_rdata <= DN'(mem_addr) + 20'h100;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0h with nothing expected (t=%0t)", name, act, $time);
    endtask

    task automatic step();
        @(negedge mclk);
        #1;
    endtask

    // Monitor samples after the bench has driven its inputs for the cycle.
    always begin
        @(negedge mclk);
        #3;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (sb_on && mem_rd) begin
                if (exp_addr_q.size() == 0) note_fail("mem_addr_extra", 32'(mem_addr));
                else check("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
            end
            if (tx_dv && !tx_waitrequest) begin
                n_xfer++;
                if (sb_on) begin
                    if (exp_q.size() == 0) note_fail("tx_data_extra", 32'(tx_data));
                    else check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
                end
            end
            if (stall_prev) begin
                check("stall_tx_dv", 32'(tx_dv), 32'd1);
                check("stall_tx_data", 32'(tx_data), 32'(stall_data));
            end
            stall_prev = tx_dv && tx_waitrequest;
            stall_data = tx_data;
            if (dac_start) begin
                if (chk_int && have_last)
                    check("dac_start_interval", 32'(cyc - last_start), 32'(cfg_period) + 32'd1);
                last_start = cyc;
                have_last  = 1'b1;
                n_start++;
            end
            if (done) n_done++;
            if (underrun) n_under++;
        end
    end

    task automatic expect_samples(input logic [AN-1:0] start_a, input int n);
        logic [AN-1:0] a;
        for (int i = 0; i < n; i++) begin
            a = start_a + AN'(i);
            exp_addr_q.push_back(a);
            exp_q.push_back(DN'(a) + 20'h100);
        end
    endtask

    task automatic start_run(input logic [AN-1:0] s, input logic [AN-1:0] e,
                             input logic lp, input logic [PN-1:0] p, input bit interval);
        cfg_start_addr = s;
        cfg_end_addr   = e;
        cfg_loop       = lp;
        cfg_period     = p;
        n_start = 0; n_done = 0; n_under = 0; n_xfer = 0;
        have_last = 1'b0;
        chk_int   = interval;
        cfg_en    = 1'b1;
        step();
        check("run_started", 32'(busy), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while (busy && k < budget) begin
            step();
            k++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic wait_dv(input int budget, input string name);
        int k = 0;
        while (!tx_dv && k < budget) begin
            step();
            k++;
        end
        check(name, 32'(tx_dv), 32'd1);
    endtask

    task automatic end_run();
        cfg_en = 1'b0;
        step();
        check("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
        check("data_q_empty", 32'(exp_q.size()), 32'd0);
        exp_addr_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int len;
        int k;

        cases[0] = '{10'd0,     10'd3,     16'd9, 0};
        cases[1] = '{10'h3FE,   10'h001,   16'd3, 0};
        cases[2] = '{10'd5,     10'd5,     16'd0, 3};
        cases[3] = '{10'd7,     10'd9,     16'd4, 0};

        repeat (3) step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_tx_dv", 32'(tx_dv), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_dac_start", 32'(dac_start), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        rst_n = 1'b1;
        repeat (2) step();
        check("idle_after_reset", 32'(busy), 32'd0);

        // One-shot runs from the table.
        for (int c = 0; c < 4; c++) begin
            len = int'(AN'(cases[c].end_a - cases[c].start_a)) + 1;
            expect_samples(cases[c].start_a, len);
            start_run(cases[c].start_a, cases[c].end_a, 1'b0, cases[c].period,
                      cases[c].exp_under == 0);
            wait_idle(len * (int'(cases[c].period) + 1) + 20, "oneshot_ends");
            check("oneshot_dac_starts", 32'(n_start), 32'(len));
            check("oneshot_done", 32'(n_done), 32'd1);
            check("oneshot_underruns", 32'(n_under), 32'(cases[c].exp_under));
            end_run();
        end

        // Looping run: 12 ticks over 0..3, then disable.
        for (int i = 0; i < 13; i++) exp_addr_q.push_back(AN'(i % 4));
        for (int i = 0; i < 12; i++) exp_q.push_back(DN'(i % 4) + 20'h100);
        start_run(10'd0, 10'd3, 1'b1, 16'd9, 1'b1);
        k = 0;
        while (n_start < 12 && k < 200) begin
            step();
            k++;
        end
        check("loop_dac_starts", 32'(n_start), 32'd12);
        step();
        cfg_en = 1'b0;
        step();
        check("loop_stopped", 32'(busy), 32'd0);
        check("loop_no_done", 32'(n_done), 32'd0);
        check("loop_no_underrun", 32'(n_under), 32'd0);
        end_run();

        // Back-pressure on sample 1 for 25 cycles.
        expect_samples(10'd0, 4);
        start_run(10'd0, 10'd3, 1'b0, 16'd9, 1'b0);
        k = 0;
        while (n_xfer < 1 && k < 50) begin
            step();
            k++;
        end
        check("stall_first_xfer", 32'(n_xfer), 32'd1);
        tx_waitrequest = 1'b1;
        wait_dv(50, "stall_dv_seen");
        check("stall_sample1", 32'(tx_data), 32'h101);
        repeat (25) step();
        tx_waitrequest = 1'b0;
        wait_idle(100, "stall_ends");
        check("stall_dac_starts", 32'(n_start), 32'd4);
        check("stall_underruns", 32'(n_under), 32'd2);
        check("stall_done", 32'(n_done), 32'd1);
        end_run();

        // Abort while the FIFO stalls: transfer must finish, no done.
        expect_samples(10'd0, 1);
        tx_waitrequest = 1'b1;
        start_run(10'd0, 10'd3, 1'b0, 16'd9, 1'b0);
        wait_dv(20, "abort_dv_seen");
        cfg_en = 1'b0;
        repeat (3) step();
        check("abort_holds_dv", 32'(tx_dv), 32'd1);
        check("abort_holds_busy", 32'(busy), 32'd1);
        tx_waitrequest = 1'b0;
        step();
        check("abort_idle", 32'(busy), 32'd0);
        check("abort_xfer", 32'(n_xfer), 32'd1);
        check("abort_no_done", 32'(n_done), 32'd0);
        end_run();

        // Reset mid-run, with cfg_en still high across the release.
        sb_on = 1'b0;
        tx_waitrequest = 1'b1;
        start_run(10'd2, 10'd3, 1'b1, 16'd9, 1'b0);
        wait_dv(20, "midrst_dv_seen");
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_tx_dv", 32'(tx_dv), 32'd0);
        check("midrst_tx_data", 32'(tx_data), 32'd0);
        check("midrst_mem_rd", 32'(mem_rd), 32'd0);
        check("midrst_mem_addr", 32'(mem_addr), 32'd0);
        check("midrst_dac_start", 32'(dac_start), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_underrun", 32'(underrun), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        tx_waitrequest = 1'b0;
        step();
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_mem_rd", 32'(mem_rd), 32'd1);
        check("restart_mem_addr", 32'(mem_addr), 32'd2);
        cfg_en = 1'b0;
        repeat (2) step();
        check("restart_stopped", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
